// File: rtl/spi_controller.sv
// SPI mode-3 master that streams a block of bytes between a byte-wide memory port and an SPI slave.
// Define SPI_LSB_FIRST_EN to shift LSB first on both mosi and miso (default: MSB first).
module spi_controller #(
    parameter int MEMORY_SIZE_IN_BYTES = 512,
    localparam int AW = (MEMORY_SIZE_IN_BYTES > 1) ? $clog2(MEMORY_SIZE_IN_BYTES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          mosi,
    input  logic          miso,
    output logic          sclk,
    input  logic [7:0]    data_in,
    output logic [7:0]    data_out,
    output logic          wr,
    input  logic          op,
    input  logic          start,
    output logic [AW-1:0] address,
    input  logic [AW-1:0] size,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE,
        DONE
    } state_e;

    localparam logic [AW:0] MEM_BYTES = (AW + 1)'(MEMORY_SIZE_IN_BYTES);

    state_e        state_q, state_d;
    logic          op_q, op_d;
    logic [AW-1:0] size_q, size_d;
    logic [AW-1:0] address_q, address_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_out_q, data_out_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;

    logic [7:0]    shreg_next;
    logic          mosi_bit;
    logic [AW-1:0] size_clamped;

`ifdef SPI_LSB_FIRST_EN
    assign shreg_next = {miso, shreg_q[7:1]};
    assign mosi_bit   = shreg_q[0];
`else
    assign shreg_next = {shreg_q[6:0], miso};
    assign mosi_bit   = shreg_q[7];
`endif

    // Only reachable for non-power-of-two depths; keeps the last address inside the memory.
    assign size_clamped = ({1'b0, size} > MEM_BYTES) ? MEM_BYTES[AW-1:0] : size;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        size_d     = size_q;
        address_d  = address_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        wr_d       = 1'b0;
        done_d     = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op;
                    size_d    = size_clamped;
                    address_d = '0;
                    done_d    = 1'b0;
                    state_d   = (size_clamped == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                shreg_d   = op_q ? data_in : 8'h00;
                bit_cnt_d = 4'd0;
                sclk_d    = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (!bit_cnt_q[0]) begin
                    sclk_d = 1'b0;
                    mosi_d = op_q ? mosi_bit : 1'b1;
                end else begin
                    sclk_d  = 1'b1;
                    shreg_d = shreg_next;
                    if (bit_cnt_q == 4'd15) begin
                        state_d = STORE;
                        // NOTE: wr and data_out are raised on entry so they are valid during
                        // STORE, while address still names the byte just received.
                        if (!op_q) begin
                            wr_d       = 1'b1;
                            data_out_d = shreg_next;
                        end
                    end
                end
            end
            STORE: begin
                if (address_q == size_q - AW'(1)) begin
                    state_d = DONE;
                end else begin
                    address_d = address_q + AW'(1);
                    state_d   = LOAD;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                sclk_d  = 1'b1;
                mosi_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every piece of state is a plain flop with an async reset; there is no storage array here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= 1'b0;
            size_q     <= '0;
            address_q  <= '0;
            shreg_q    <= 8'h00;
            data_out_q <= 8'h00;
            bit_cnt_q  <= 4'd0;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b1;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            size_q     <= size_d;
            address_q  <= address_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
        end
    end

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign wr       = wr_q;
    assign done     = done_q;
    assign address  = address_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: a bit-level SPI slave, a byte memory and a
// transaction-level expectation (bytes moved, edge counts, latency) derived from the protocol rules.
module tb_spi_controller;

    localparam int MEM = 512;
    localparam int AW  = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mosi, sclk, wr, done;
    logic          miso = 1'b1;
    logic [7:0]    data_in, data_out;
    logic          op = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] address;
    logic [AW-1:0] size = '0;

    logic [7:0] mem [0:MEM-1];
    assign data_in = mem[address];

    spi_controller #(.MEMORY_SIZE_IN_BYTES(MEM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mosi     (mosi),
        .miso     (miso),
        .sclk     (sclk),
        .data_in  (data_in),
        .data_out (data_out),
        .wr       (wr),
        .op       (op),
        .start    (start),
        .address  (address),
        .size     (size),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave / bus observer state
    logic [7:0] slave_q[$];
    logic [7:0] mosi_log[$];
    int         wr_addr_log[$];
    logic [7:0] wr_data_log[$];
    int cyc = 0, last_fall = 0, fall_cnt = 0, period_err = 0, wr_wide = 0, max_addr = 0;
    int tx_bit = 0, rx_bit = 0;
    logic [7:0] cur_tx = 8'hFF, rx_sh = 8'h00;
    logic sclk_prev = 1'b1, wr_prev = 1'b0;

    function automatic int bit_pos(input int k);
`ifdef SPI_LSB_FIRST_EN
        return k;
`else
        return 7 - k;
`endif
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sclk_prev = 1'b1;
            wr_prev   = 1'b0;
            tx_bit    = 0;
            rx_bit    = 0;
        end else begin
            if (sclk_prev && !sclk) begin
                if ((fall_cnt % 8) != 0 && (cyc - last_fall) != 2) period_err++;
                last_fall = cyc;
                fall_cnt++;
                if (tx_bit == 0) begin
                    if (slave_q.size() > 0) cur_tx = slave_q.pop_front();
                    else cur_tx = 8'hFF;
                end
                miso   = cur_tx[bit_pos(tx_bit)];
                tx_bit = (tx_bit + 1) % 8;
            end
            if (!sclk_prev && sclk) begin
                rx_sh[bit_pos(rx_bit)] = mosi;
                if (rx_bit == 7) mosi_log.push_back(rx_sh);
                rx_bit = (rx_bit + 1) % 8;
            end
            if (wr) begin
                wr_addr_log.push_back(int'(address));
                wr_data_log.push_back(data_out);
                if (wr_prev) wr_wide++;
            end
            if (int'(address) > max_addr) max_addr = int'(address);
            wr_prev   = wr;
            sclk_prev = sclk;
        end
    end

    task automatic clear_logs();
        mosi_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        fall_cnt   = 0;
        period_err = 0;
        wr_wide    = 0;
    endtask

    task automatic prep_random(input int n);
        slave_q.delete();
        for (int i = 0; i < n + 1; i++) slave_q.push_back(8'($urandom));
        for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
    endtask

    task automatic run_xfer(input logic op_i, input int n, input bit poke_busy, input string tag);
        logic [7:0] exp_rd[$];
        logic [7:0] exp_wr[$];
        int k;
        bit seen;
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(slave_q[i]);
            exp_wr.push_back(mem[i]);
        end
        clear_logs();
        @(posedge clk); #1;
        op    = op_i;
        size  = AW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op    = ~op_i;
        size  = AW'($urandom);
        k     = 0;
        seen  = 1'b0;
        while (!seen && k < 18 * n + 40) begin
            @(posedge clk); #1;
            k++;
            if (poke_busy) start = (k == 20);
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        @(negedge clk);
        if (!seen) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_latency"}, k, 18 * n + 1);
        check({tag, "_sclk_falls"}, fall_cnt, 8 * n);
        check({tag, "_sclk_period"}, period_err, 0);
        check({tag, "_wr_width"}, wr_wide, 0);
        check({tag, "_sclk_idle"}, sclk, 1'b1);
        if (op_i == 1'b0) begin
            check({tag, "_wr_count"}, wr_addr_log.size(), n);
            for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
                check({tag, "_wr_addr"}, wr_addr_log[i], i);
                check({tag, "_wr_data"}, wr_data_log[i], exp_rd[i]);
            end
        end else begin
            check({tag, "_wr_count"}, wr_addr_log.size(), 0);
            check({tag, "_mosi_count"}, mosi_log.size(), n);
            for (int i = 0; i < n && i < mosi_log.size(); i++)
                check({tag, "_mosi_byte"}, mosi_log[i], exp_wr[i]);
        end
        check({tag, "_addr_in_range"}, (max_addr <= MEM - 1), 1'b1);
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) mem[i] = 8'h00;

        #12;
        check("rst_sclk", sclk, 1'b1);
        check("rst_mosi", mosi, 1'b1);
        check("rst_wr", wr, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_address", address, 0);
        check("rst_data_out", data_out, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed read: slave sends F0, CA, 30; only two bytes are consumed.
        slave_q.delete();
        slave_q.push_back(8'hF0);
        slave_q.push_back(8'hCA);
        slave_q.push_back(8'h30);
        run_xfer(1'b0, 2, 1'b0, "rd2");
        check("rd2_done_held", done, 1'b1);

        // Directed write: AA, 01, 02 out of memory.
        prep_random(3);
        mem[0] = 8'hAA;
        mem[1] = 8'h01;
        mem[2] = 8'h02;
        run_xfer(1'b1, 3, 1'b0, "wr3");

        // Zero-length transfer.
        run_xfer(1'b0, 0, 1'b0, "size0");

        // start pulsed while busy must not change the transfer.
        prep_random(3);
        run_xfer(1'b0, 3, 1'b1, "busy_rd");
        prep_random(2);
        run_xfer(1'b1, 2, 1'b1, "busy_wr");

        // Reset during the first byte of a two-byte read.
        prep_random(2);
        clear_logs();
        @(posedge clk); #1;
        op    = 1'b0;
        size  = AW'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_sclk", sclk, 1'b1);
        check("midrst_wr", wr, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_address", address, 0);
        @(negedge clk);
        check("midrst_no_wr", wr_addr_log.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        prep_random(2);
        run_xfer(1'b0, 2, 1'b0, "post_rst");

        // Randomized transfers.
        for (int t = 0; t < 8; t++) begin
            int n;
            logic o;
            n = $urandom_range(1, 6);
            o = 1'($urandom_range(0, 1));
            prep_random(n);
            run_xfer(o, n, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
